serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that sequences one shared `full_adder` cell over WIDTH-bit operands, one bit per clock, LSB first. It runs a start/busy/done handshake, captures the operands and the carry-in, steps the full adder WIDTH times through shift registers and a carry flip-flop, then presents the WIDTH-bit sum and the carry-out. It sits between a requesting controller and the single-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the accepting edge
- b  in  WIDTH  operand B; captured on the accepting edge
- cin  in  1  carry-in; captured on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse; result valid
- sum  out  WIDTH  result; held until the next accepted start
- cout  out  1  final carry; held with sum

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1. The full adder takes a_sr[0], b_sr[0] and carry_q.
    - The sum bit shifts into the MSB of sum_sr (right shift).
    - a_sr and b_sr shift right; carry_q takes the adder carry; cnt increments.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE→RUN on start=1. Load a_sr=a, b_sr=b, carry_q=cin, cnt=0, sum_sr=0.
  - RUN→DONE on the edge where cnt reaches WIDTH-1, which is the last bit.
  - DONE→IDLE unconditionally.
- Outputs:
  - sum = sum_sr and cout = carry_q, registered.
  - Both hold their value through IDLE and update only during RUN.
- start while in RUN or DONE is ignored. It is not queued.
- Operand and cin changes after the accepting edge have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is fully represented by cout.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Reset value of every output is 0: busy=0, done=0, sum=0, cout=0. State is IDLE, all internal registers are 0.
- Accepting edge E0 (start=1 in IDLE): busy goes high in the cycle after E0.
- Bits are processed on edges E1..EWIDTH. done is high in the cycle after EWIDTH, and busy is low in that cycle.
- Latency is WIDTH+1 edges from the accepting edge to the end of the done cycle.
- Throughput: a new start is accepted in the first IDLE cycle after done. The minimum start-to-start spacing is WIDTH+2 cycles.
- Reset mid-operation, in any state: the next cycle is IDLE with every output at 0. No partial result is held.
- Reset has priority over start on the same edge.

## Structure
- Shared package or header `serial_adder_pkg`:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the counter width function clog2(WIDTH).
- Sub-module: the existing `full_adder`. Its port order is (a, b, cin, c, s), where c is the carry-out and s is the sum. It is instantiated once, combinationally, in the bit path.
- Everything else stays in one module: the FSM, cnt, a_sr, b_sr, sum_sr and carry_q.
- The unreachable state encoding 2'd3 returns to IDLE.

## Test plan
- **Zero operands**: WIDTH=8, a=0x00, b=0x00, cin=0, start pulse.
  - busy is high for 8 cycles, then done is high for 1 cycle with sum=0x00, cout=0.
- **Carry ripple**: a=0xFF, b=0x01, cin=0.
  - sum=0x00, cout=1.
  - The carry must propagate through all 8 serial steps.
- **Carry-in effect**: a=0xA5, b=0x5A, cin=1.
  - sum=0x00, cout=1 (0xFF+1=0x100).
  - Repeating with cin=0 gives sum=0xFF, cout=0.
- **Busy rejection**: start with a=0x12, b=0x34. Three cycles later, pulse start again with a=0xFF, b=0xFF and also change a/b.
  - Exactly one done, with sum=0x46, cout=0.
- **Reset mid-operation**: assert rst in the 4th RUN cycle.
  - Next cycle: busy=0, done=0, sum=0x00, cout=0.
  - No done pulse appears afterwards.
  - A following start with 0x7F+0x01, cin=0 gives sum=0x80, cout=0.
- **Exhaustive small width**: WIDTH=2, all 32 combinations of a, b and cin, with each start issued in the first IDLE cycle after the previous done.
  - {cout,sum} equals a+b+cin every time.
  - Start-to-start spacing is 4 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// counter sizing helper.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to count 0..n-1; never less than one so WIDTH=1 still has a counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic c,
  output logic s
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: steps one full_adder over WIDTH-bit operands,
// LSB first, behind a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_c;
  logic             fa_s;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register; busy/done are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == RUN)  busy_nxt = 1'b1;
    if (state_nxt == DONE) done_nxt = 1'b1;
  end

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry_q),
    .c   (fa_c),
    .s   (fa_s)
  );

  // Operand capture and one-bit-per-cycle shift datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= WIDTH'({fa_s, sum_sr} >> 1);
          carry_q <= fa_c;
          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sr;
  assign cout = carry_q;

endmodule
